// File: rtl/add8_seq_pkg.sv
// Shared constants and state encoding for the byte-serial add/subtract sequencer.
package add8_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/add8_seq_ctrl_if.sv
// Operand request (valid/ready) and result (valid/ready) channels of the sequencer.
interface add8_seq_ctrl_if #(
    parameter int W = 32
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    // Operand source and result sink side
    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

endinterface

// File: rtl/add8_rc.sv
// Combinational 8-bit ripple-carry adder slice; each bit is an xor/nand full adder.
module add8_rc
    import add8_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] x,
    input  logic [BYTE_W-1:0] y,
    input  logic              ci,
    output logic [BYTE_W-1:0] s,
    output logic              co
);

    logic [BYTE_W:0]   c;
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] g_n;
    logic [BYTE_W-1:0] t_n;

    assign c[0] = ci;

    for (genvar k = 0; k < BYTE_W; k++) begin : g_bit
        assign p[k]     = x[k] ^ y[k];
        assign s[k]     = p[k] ^ c[k];
        assign g_n[k]   = ~(x[k] & y[k]);
        assign t_n[k]   = ~(p[k] & c[k]);
        assign c[k + 1] = ~(g_n[k] & t_n[k]);
    end

    assign co = c[BYTE_W];

endmodule

// File: rtl/add8_seq_ctrl.sv
// Multi-cycle NBYTES-wide add/subtract built around a single shared 8-bit
// ripple-carry slice, processed LSB byte first with a held carry.
module add8_seq_ctrl
    import add8_seq_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int SETTLE = 1
) (
    input logic           clk,
    input logic           rst,
    add8_seq_ctrl_if.slave bus
);

    localparam int W  = NBYTES * BYTE_W;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [IW-1:0] LAST_BYTE   = IW'(NBYTES - 1);
    localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE - 1);

    state_t        state_q;
    state_t        state_d;
    logic          accept;
    logic          step;
    logic          last;

    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  acc_d;
    logic          carry_q;
    logic [IW-1:0] byte_q;
    logic [SW-1:0] settle_q;

    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic          ovf_q;

    logic [BYTE_W-1:0] sx;
    logic [BYTE_W-1:0] sy;
    logic [BYTE_W-1:0] ss;
    logic              sco;

    assign bus.in_ready  = (state_q == IDLE) & ~rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;

    assign sx = a_q[byte_q * BYTE_W +: BYTE_W];
    assign sy = b_q[byte_q * BYTE_W +: BYTE_W];

    add8_rc u_rc (
        .x  (sx),
        .y  (sy),
        .ci (carry_q),
        .s  (ss),
        .co (sco)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (settle_q == LAST_SETTLE) begin
                    step = 1'b1;
                    if (byte_q == LAST_BYTE) begin
                        last    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Working result with the current slice byte merged in
    always_comb begin
        acc_d = acc_q;
        acc_d[byte_q * BYTE_W +: BYTE_W] = ss;
    end

    // Operand, carry, counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            byte_q   <= '0;
            settle_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_q      <= bus.in_a;
            b_q      <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry_q  <= bus.in_sub | bus.in_cin;
            acc_q    <= '0;
            byte_q   <= '0;
            settle_q <= '0;
        end else if (state_q == RUN) begin
            if (step) begin
                acc_q    <= acc_d;
                carry_q  <= sco;
                settle_q <= '0;
                if (!last) begin
                    byte_q <= byte_q + 1'b1;
                end
            end else begin
                settle_q <= settle_q + 1'b1;
            end
            // Visible outputs only change on the final step, so they hold during RUN
            if (last) begin
                sum_q  <= acc_d;
                cout_q <= sco;
                ovf_q  <= (a_q[W-1] == b_q[W-1]) & (acc_d[W-1] != a_q[W-1]);
            end
        end
    end

endmodule

// File: tb/tb_add8_seq_ctrl.sv
// Directed bench for add8_seq_ctrl: three instances cover the 4x1, 2x3 and
// 4x3 byte/settle configurations; expected values are hand-computed constants.
module tb_add8_seq_ctrl;

    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] last_sum [3];

    always #5 clk = ~clk;

    add8_seq_ctrl_if #(.W(32)) bus0 ();
    add8_seq_ctrl_if #(.W(16)) bus1 ();
    add8_seq_ctrl_if #(.W(32)) bus2 ();

    add8_seq_ctrl #(.NBYTES(4), .SETTLE(1)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    add8_seq_ctrl #(.NBYTES(2), .SETTLE(3)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
    add8_seq_ctrl #(.NBYTES(4), .SETTLE(3)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic cin);
        case (d)
            0: begin bus0.in_valid = v; bus0.in_a = a; bus0.in_b = b; bus0.in_sub = sub; bus0.in_cin = cin; end
            1: begin bus1.in_valid = v; bus1.in_a = a[15:0]; bus1.in_b = b[15:0]; bus1.in_sub = sub; bus1.in_cin = cin; end
            default: begin bus2.in_valid = v; bus2.in_a = a; bus2.in_b = b; bus2.in_sub = sub; bus2.in_cin = cin; end
        endcase
    endtask

    task automatic set_oready(input int d, input logic r);
        case (d)
            0: bus0.out_ready = r;
            1: bus1.out_ready = r;
            default: bus2.out_ready = r;
        endcase
    endtask

    function automatic logic ov(input int d);
        case (d)
            0: return bus0.out_valid;
            1: return bus1.out_valid;
            default: return bus2.out_valid;
        endcase
    endfunction

    function automatic logic irdy(input int d);
        case (d)
            0: return bus0.in_ready;
            1: return bus1.in_ready;
            default: return bus2.in_ready;
        endcase
    endfunction

    function automatic logic [31:0] osum(input int d);
        case (d)
            0: return bus0.out_sum;
            1: return {16'h0000, bus1.out_sum};
            default: return bus2.out_sum;
        endcase
    endfunction

    function automatic logic ocout(input int d);
        case (d)
            0: return bus0.out_cout;
            1: return bus1.out_cout;
            default: return bus2.out_cout;
        endcase
    endfunction

    function automatic logic oovf(input int d);
        case (d)
            0: return bus0.out_ovf;
            1: return bus1.out_ovf;
            default: return bus2.out_ovf;
        endcase
    endfunction

    // One full transaction: issue, optional ignored pulse in RUN, optional
    // 10-cycle backpressure in DONE, then result handshake.
    task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic cin, input int exp_lat,
                         input logic [31:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                         input bit pulse, input bit hold, input string tag);
        int n;
        @(negedge clk);
        chk({tag, ":ready_idle"}, irdy(d), 1);
        drive(d, 1'b1, a, b, sub, cin);
        @(posedge clk);
        @(negedge clk);
        n = 0;
        chk({tag, ":ready_run"}, irdy(d), 0);
        chk({tag, ":sum_held"}, osum(d), last_sum[d]);
        if (pulse) begin
            drive(d, 1'b1, ~a, ~b, ~sub, ~cin);
            @(posedge clk);
            n++;
            @(negedge clk);
            chk({tag, ":ready_pulse"}, irdy(d), 0);
        end
        drive(d, 1'b0, a, b, sub, cin);
        if (hold) set_oready(d, 1'b0);
        while (!ov(d) && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({tag, ":latency"}, n, exp_lat);
        chk({tag, ":sum"}, osum(d), exp_sum);
        chk({tag, ":cout"}, ocout(d), exp_cout);
        chk({tag, ":ovf"}, oovf(d), exp_ovf);
        chk({tag, ":ready_done"}, irdy(d), 0);
        if (hold) begin
            for (int k = 0; k < 10; k++) begin
                @(posedge clk);
                @(negedge clk);
                chk({tag, ":hold_valid"}, ov(d), 1);
                chk({tag, ":hold_sum"}, osum(d), exp_sum);
                chk({tag, ":hold_ovf"}, oovf(d), exp_ovf);
                chk({tag, ":hold_ready"}, irdy(d), 0);
            end
            set_oready(d, 1'b1);
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, ":valid_low"}, ov(d), 0);
        chk({tag, ":ready_back"}, irdy(d), 1);
        last_sum[d] = exp_sum;
    endtask

    initial begin
        int bad;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        for (int d = 0; d < 3; d++) begin
            drive(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            set_oready(d, 1'b1);
            last_sum[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", irdy(d), 0);
            chk("rst_valid", ov(d), 0);
            chk("rst_sum", osum(d), 0);
            chk("rst_cout", ocout(d), 0);
            chk("rst_ovf", oovf(d), 0);
        end
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk("rst_release_ready", irdy(d), 1);

        do_op(0, 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 4, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0, "add_ff_1");
        do_op(0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 4, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, "add_cin_wrap");
        do_op(0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, "add_ovf_bp");
        do_op(0, 32'h00000005, 32'h00000007, 1'b1, 1'b1, 4, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, "sub_5_7");
        do_op(0, 32'h80000000, 32'h00000001, 1'b1, 1'b0, 4, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, "sub_ovf");

        do_op(1, 32'h000001FF, 32'h00000001, 1'b0, 1'b0, 6, 32'h00000200, 1'b0, 1'b0, 1'b1, 1'b0, "s3_add_pulse");

        // Abort a 4x3 operation with reset sampled during byte 1
        @(negedge clk);
        drive(2, 1'b1, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(2, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst2 = 1'b1;
        #1;
        chk("abort_ready_in_rst", irdy(2), 0);
        @(posedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        chk("abort_ready_after", irdy(2), 1);
        chk("abort_valid", ov(2), 0);
        chk("abort_sum", osum(2), 0);
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (ov(2)) bad++;
        end
        chk("abort_no_valid", bad, 0);
        do_op(2, 32'h12345678, 32'h11111111, 1'b0, 1'b0, 12, 32'h23456789, 1'b0, 1'b0, 1'b0, 1'b0, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
